pll_reset_sequencer: RTL

Consumes the raw lock output of an iCE40 PLL wrapper and produces clean, staged, synchronous resets for the logic clocked by the PLL output. Sits directly after the PLL in every top level, clocked by the PLL's generated clock. It synchronises the asynchronous lock signal and requires lock to stay stable for a programmable interval. It then releases a vector of domain resets one stage at a time, and re-asserts all of them if lock is lost.

---
 rtl/pll_reset_pkg.sv | 21 ++
 rtl/pll_reset_sequencer_sync2.sv | 34 +++
 rtl/pll_reset_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pll_reset_pkg.sv
// ============================================================================
// Module  : pll_reset_pkg
// Brief   : Shared types and constants for the PLL reset sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pll_reset_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STABLE  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_e;

  localparam int LOSS_COUNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/pll_reset_sequencer_sync2.sv
// ============================================================================
// Module  : sync2
// Brief   : Two-flop synchroniser with synchronous active-high clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d_in,
  output logic q_out
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d_in};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q[1];

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// Module  : pll_reset_sequencer
// Brief   : Qualifies PLL lock and releases staged domain resets in order.
//           Optional loss counter enabled by defining PLL_RESET_LOSS_COUNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int N_STAGES      = 3,
  parameter int STAGE_GAP     = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pll_lock,
  output logic [N_STAGES-1:0] reset_out,
  output logic                ready
`ifdef PLL_RESET_LOSS_COUNT_EN
  ,
  output logic [LOSS_COUNT_W-1:0] loss_count
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int GAP_W = $clog2(STAGE_GAP + 1);
  localparam int IDX_W = $clog2(N_STAGES + 1);

  logic lock_s;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    stable_cnt_q, stable_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]    stage_idx_q, stage_idx_d;
  logic [N_STAGES-1:0] reset_out_q, reset_out_d;
  logic                ready_q, ready_d;

  logic release_start;
  logic stage_step;
  logic last_step;

  sync2 u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d_in  (pll_lock),
    .q_out (lock_s)
  );

  // A single-cycle qualification window releases straight out of HOLD.
  always_comb begin
    release_start = lock_s &&
                    (((state_q == HOLD) && (STABLE_CYCLES == 1)) ||
                     ((state_q == STABLE) && (stable_cnt_q == CNT_W'(STABLE_CYCLES - 1))));
    stage_step    = lock_s && (state_q == RELEASE) && (gap_cnt_q == GAP_W'(STAGE_GAP - 1));
    last_step     = stage_step && (stage_idx_q == IDX_W'(N_STAGES - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= HOLD;
      stable_cnt_q <= '0;
      gap_cnt_q    <= '0;
      stage_idx_q  <= '0;
      reset_out_q  <= '1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      stage_idx_q  <= stage_idx_d;
      reset_out_q  <= reset_out_d;
      ready_q      <= ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    stage_idx_d  = stage_idx_q;
    if (!lock_s) begin
      state_d      = HOLD;
      stable_cnt_d = '0;
      gap_cnt_d    = '0;
      stage_idx_d  = '0;
    end else begin
      case (state_q)
        HOLD: begin
          state_d      = STABLE;
          stable_cnt_d = CNT_W'(1);
        end
        STABLE: begin
          stable_cnt_d = stable_cnt_q + CNT_W'(1);
        end
        RELEASE: begin
          if (stage_step) begin
            gap_cnt_d   = '0;
            stage_idx_d = stage_idx_q + IDX_W'(1);
            if (last_step) begin
              state_d = RUN;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
      if (release_start) begin
        state_d     = (N_STAGES == 1) ? RUN : RELEASE;
        gap_cnt_d   = '0;
        stage_idx_d = IDX_W'(1);
      end
    end
  end

  always_comb begin
    reset_out_d = reset_out_q;
    ready_d     = ready_q;
    if (!lock_s) begin
      reset_out_d = '1;
      ready_d     = 1'b0;
    end else begin
      if (release_start) begin
        reset_out_d[0] = 1'b0;
        if (N_STAGES == 1) begin
          ready_d = 1'b1;
        end
      end
      for (int k = 1; k < N_STAGES; k++) begin
        if (stage_step && (stage_idx_q == IDX_W'(k))) begin
          reset_out_d[k] = 1'b0;
        end
      end
      if (last_step) begin
        ready_d = 1'b1;
      end
    end
  end

  assign reset_out = reset_out_q;
  assign ready     = ready_q;

`ifdef PLL_RESET_LOSS_COUNT_EN
  logic [LOSS_COUNT_W-1:0] loss_q, loss_d;
  logic                    lock_lost;

  // Only losses after release has begun are counted; STABLE drop-outs are not.
  always_comb begin
    lock_lost = !lock_s && ((state_q == RELEASE) || (state_q == RUN));
    loss_d    = loss_q;
    if (lock_lost && (loss_q != {LOSS_COUNT_W{1'b1}})) begin
      loss_d = loss_q + LOSS_COUNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_count = loss_q;
`endif

endmodule

`default_nettype wire
